// File: rtl/uart_pkg.sv
// Shared UART types and constants for the RX deserializer and the baud divider.
// Holds the receive FSM encoding, mid-bit sample points, and divider rate codes.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  localparam int OVS_DEFAULT = 16;
  localparam int MID_LO      = 7;
  localparam int MID_HI      = 9;

  typedef enum logic [2:0] {
    BD_9600,
    BD_19200,
    BD_38400,
    BD_57600,
    BD_115200
  } bd_rate_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Oversample tick edge detect, rx synchronizer, in-bit tick counter and 2-of-3 mid-bit vote.
// Decision (bit_done/bit_val) is registered: one clk after the tcnt=MID_HI tick; no backpressure.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int OVS         = OVS_DEFAULT,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic os_clk,
  input  logic rx_in,
  input  logic run,
  output logic tick,
  output logic bit_val,
  output logic bit_done,
  output logic bit_last,
  output logic fall_edge
);

  logic                   os_clk_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;
  logic                   rx_q;
  logic [3:0]             tcnt;
  logic                   s_lo;
  logic                   s_mid;

  assign tick      = os_clk & ~os_clk_q;
  assign rx_s      = sync_q[SYNC_STAGES-1];
  assign fall_edge = rx_q & ~rx_s;
  assign bit_last  = (tcnt == 4'(OVS - 1));

  // Presets to 1 keep an idle line and a high os_clk from looking like edges after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      os_clk_q <= 1'b1;
      sync_q   <= '1;
      rx_q     <= 1'b1;
    end else begin
      os_clk_q <= os_clk;
      sync_q   <= {sync_q[SYNC_STAGES-2:0], rx_in};
      rx_q     <= rx_s;
    end
  end

  // tcnt is held at zero outside a frame so a stale mid-bit decision can never leak into START.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tcnt     <= 4'd0;
      s_lo     <= 1'b1;
      s_mid    <= 1'b1;
      bit_val  <= 1'b1;
      bit_done <= 1'b0;
    end else begin
      bit_done <= 1'b0;
      if (!run) begin
        tcnt <= 4'd0;
      end else if (tick) begin
        tcnt <= bit_last ? 4'd0 : tcnt + 4'd1;
        if (tcnt == 4'(MID_LO))     s_lo  <= rx_s;
        if (tcnt == 4'(MID_LO + 1)) s_mid <= rx_s;
        if (tcnt == 4'(MID_HI)) begin
          bit_val  <= maj3(s_lo, s_mid, rx_s);
          bit_done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/uart_rx_deser.sv
// UART receive deserializer: recovers 8N1/8E1/8O1 frames from the oversampled line.
// rx_valid rises 2 clk after the stop-bit mid tick; byte held until rx_ready, later frames dropped as overrun.
module uart_rx_deser
  import uart_pkg::*;
#(
  parameter int DATA_BITS   = 8,
  parameter int OVS         = OVS_DEFAULT,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 os_clk,
  input  logic                 rx_in,
  input  logic                 parity_en,
  input  logic                 parity_odd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int BW = $clog2(DATA_BITS);

  rx_state_t state_q, state_d;

  logic                 tick;
  logic                 bit_val;
  logic                 bit_done;
  logic                 bit_last;
  logic                 fall_edge;
  logic                 bit_end;
  logic                 run;
  logic                 last_bit;
  logic                 start_to_data;
  logic                 complete;
  logic                 load;
  logic [BW-1:0]        bcnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_en_q;
  logic                 par_odd_q;
  logic                 par_acc;
  logic                 perr_pend;

  uart_rx_sampler #(
    .OVS         (OVS),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sampler (
    .clk       (clk),
    .rst       (rst),
    .os_clk    (os_clk),
    .rx_in     (rx_in),
    .run       (run),
    .tick      (tick),
    .bit_val   (bit_val),
    .bit_done  (bit_done),
    .bit_last  (bit_last),
    .fall_edge (fall_edge)
  );

  assign run      = (state_q != IDLE);
  assign busy     = run;
  assign bit_end  = tick & bit_last;
  assign last_bit = (bcnt == BW'(DATA_BITS - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    start_to_data = 1'b0;
    complete      = 1'b0;
    load          = 1'b0;
    case (state_q)
      IDLE:    if (fall_edge) state_d = START;
      START: begin
        if (bit_done && bit_val) begin
          state_d = IDLE;
        end else if (bit_end) begin
          state_d       = DATA;
          start_to_data = 1'b1;
        end
      end
      DATA:    if (bit_end && last_bit) state_d = par_en_q ? PARITY : STOP;
      PARITY:  if (bit_end) state_d = STOP;
      // Leave at the stop-bit mid point so a back-to-back start edge is not missed.
      STOP: begin
        if (bit_done) begin
          state_d  = IDLE;
          complete = 1'b1;
          load     = ~rx_valid | rx_ready;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bcnt      <= '0;
      shreg     <= '0;
      par_en_q  <= 1'b0;
      par_odd_q <= 1'b0;
      par_acc   <= 1'b0;
      perr_pend <= 1'b0;
    end else begin
      if (start_to_data) begin
        bcnt      <= '0;
        par_en_q  <= parity_en;
        par_odd_q <= parity_odd;
        par_acc   <= 1'b0;
        perr_pend <= 1'b0;
      end
      if (state_q == DATA) begin
        if (bit_done) begin
          shreg   <= {bit_val, shreg[DATA_BITS-1:1]};
          par_acc <= par_acc ^ bit_val;
        end
        if (bit_end && !last_bit) bcnt <= bcnt + 1'b1;
      end
      if (state_q == PARITY && bit_done) perr_pend <= ((par_acc ^ bit_val) != par_odd_q);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (load) begin
        rx_data    <= shreg;
        parity_err <= perr_pend;
        frame_err  <= ~bit_val;
        rx_valid   <= 1'b1;
      end else if (rx_ready) begin
        rx_valid   <= 1'b0;
      end
      if (complete && !load) overrun <= 1'b1;
    end
  end

endmodule
